// File: rtl/float_pkg.sv
// Shared float result types and IEEE-style constant helpers.
package float_pkg;

  localparam int DEF_FLOAT_SIZE    = 32;
  localparam int DEF_EXPONENT_SIZE = 8;
  localparam int DEF_MANTISSA_SIZE = 23;

  // Exception flags travelling with each product word.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } float_flags_t;

  // One FIFO entry: stored word plus its flags.
  typedef struct packed {
    logic [DEF_FLOAT_SIZE-1:0] data;
    logic                      overflow;
    logic                      underflow;
    logic                      inexact;
  } float_result_t;

  // Signed infinity: all-ones exponent, zero mantissa.
  function automatic logic [DEF_FLOAT_SIZE-1:0] make_inf(input logic sign);
    return {sign, {DEF_EXPONENT_SIZE{1'b1}}, {DEF_MANTISSA_SIZE{1'b0}}};
  endfunction

  // Signed zero.
  function automatic logic [DEF_FLOAT_SIZE-1:0] make_zero(input logic sign);
    return {sign, {(DEF_FLOAT_SIZE-1){1'b0}}};
  endfunction

endpackage

// File: rtl/float_exception_status.sv
// Sticky exception flags and saturating overflow/underflow counter.
// Only accepted pushes (push_fire) are observed; a set in the same
// cycle as clear_sticky wins so no event is lost.
module float_exception_status import float_pkg::*; #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_fire,
  input  float_flags_t           flags,
  input  logic                   clear_sticky,
  output logic                   sticky_overflow,
  output logic                   sticky_underflow,
  output logic                   sticky_inexact,
  output logic [COUNT_WIDTH-1:0] exc_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic set_ovf, set_unf, set_inx, inc;

  assign set_ovf = push_fire & flags.overflow;
  assign set_unf = push_fire & flags.underflow;
  assign set_inx = push_fire & flags.inexact;
  assign inc     = set_ovf | set_unf;

  // Sticky flags: set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_overflow  <= 1'b0;
      sticky_underflow <= 1'b0;
      sticky_inexact   <= 1'b0;
    end else begin
      sticky_overflow  <= set_ovf | (sticky_overflow  & ~clear_sticky);
      sticky_underflow <= set_unf | (sticky_underflow & ~clear_sticky);
      sticky_inexact   <= set_inx | (sticky_inexact   & ~clear_sticky);
    end
  end

  // Exception counter: clear restarts at the current event, else saturating +1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      exc_count <= '0;
    else if (clear_sticky)
      exc_count <= {{(COUNT_WIDTH-1){1'b0}}, inc};
    else if (inc && exc_count != CNT_MAX)
      exc_count <= exc_count + 1'b1;
  end

endmodule

// File: rtl/float_result_queue.sv
// Registered FWFT result queue behind the float multiplier.
// Optional: define FLOAT_RESULT_SATURATE_EN to store overflow entries as
// signed infinity and underflow entries as signed zero (flags unchanged).
module float_result_queue import float_pkg::*; #(
  parameter int FLOAT_SIZE    = DEF_FLOAT_SIZE,
  parameter int EXPONENT_SIZE = DEF_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = DEF_MANTISSA_SIZE,
  parameter int DEPTH         = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FLOAT_SIZE-1:0]    in_data,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic                     in_inexact,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLOAT_SIZE-1:0]    out_data,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic                     out_inexact,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_sticky,
  output logic                     sticky_overflow,
  output logic                     sticky_underflow,
  output logic                     sticky_inexact,
  output logic [COUNT_WIDTH-1:0]   exc_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SIGN_B = EXPONENT_SIZE + MANTISSA_SIZE;

  float_result_t          mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       cnt;
  logic                   push, pop;
  logic                   sign;
  logic [SIGN_B-1:0]      mag;
  logic [FLOAT_SIZE-1:0]  wdata;
  float_result_t          head;
  float_flags_t           in_flags;

  assign in_ready  = (cnt < CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  assign sign = in_data[SIGN_B];
  assign mag  = in_data[SIGN_B-1:0];

  // Write-path word: verbatim, or IEEE-saturated when the option is built in.
  // Overflow takes precedence if a producer ever flags both.
  always_comb begin
    wdata = {sign, mag};
`ifdef FLOAT_RESULT_SATURATE_EN
    if (in_overflow)
      wdata = make_inf(sign);
    else if (in_underflow)
      wdata = make_zero(sign);
`endif
  end

  // Storage: no reset needed, contents are qualified by cnt.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{data: wdata, overflow: in_overflow,
                       underflow: in_underflow, inexact: in_inexact};
  end

  // Pointers and occupancy; power-of-two DEPTH makes the pointers wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head presentation: zeros when empty so stale storage never leaks out.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_data      = head.data;
  assign out_overflow  = head.overflow;
  assign out_underflow = head.underflow;
  assign out_inexact   = head.inexact;

  assign in_flags = '{overflow: in_overflow, underflow: in_underflow,
                      inexact: in_inexact};

  float_exception_status #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_status (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_fire        (push),
    .flags            (in_flags),
    .clear_sticky     (clear_sticky),
    .sticky_overflow  (sticky_overflow),
    .sticky_underflow (sticky_underflow),
    .sticky_inexact   (sticky_inexact),
    .exc_count        (exc_count)
  );

endmodule

// File: tb/tb_float_result_queue.sv
// Self-checking bench for float_result_queue (DEPTH=4, COUNT_WIDTH=2).
module tb_float_result_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int EXC_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        in_overflow, in_underflow, in_inexact;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_overflow, out_underflow, out_inexact;
  logic [2:0]  count;
  logic        clear_sticky;
  logic        sticky_overflow, sticky_underflow, sticky_inexact;
  logic [CW-1:0] exc_count;

  float_result_queue #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_overflow(in_overflow), .in_underflow(in_underflow), .in_inexact(in_inexact),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact),
    .count(count), .clear_sticky(clear_sticky),
    .sticky_overflow(sticky_overflow), .sticky_underflow(sticky_underflow),
    .sticky_inexact(sticky_inexact), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of words with flags, plus status values.
  typedef struct {
    logic [31:0] d;
    logic o, u, x;
  } ent_t;

  ent_t m_q[$];
  logic m_so, m_su, m_sx;
  int   m_exc;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] stored_word(logic [31:0] d, logic o, logic u);
`ifdef FLOAT_RESULT_SATURATE_EN
    if (o) return {d[31], 8'hFF, 23'h0};
    if (u) return {d[31], 31'h0};
`endif
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    ent_t h;
    h = '{d: 32'h0, o: 1'b0, u: 1'b0, x: 1'b0};
    if (m_q.size() != 0) h = m_q[0];
    chk({tag, ".count"},     32'(count),     32'(m_q.size()));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    chk({tag, ".out_data"},  out_data,       h.d);
    chk({tag, ".out_flags"}, {29'h0, out_overflow, out_underflow, out_inexact},
                             {29'h0, h.o, h.u, h.x});
    chk({tag, ".sticky"},    {29'h0, sticky_overflow, sticky_underflow, sticky_inexact},
                             {29'h0, m_so, m_su, m_sx});
    chk({tag, ".exc_count"}, 32'(exc_count), 32'(m_exc));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check 1 later.
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic o, input logic u, input logic x,
                      input logic r, input logic clr);
    bit acc, pp;
    @(negedge clk);
    in_valid = v; in_data = d; in_overflow = o; in_underflow = u; in_inexact = x;
    out_ready = r; clear_sticky = clr;
    acc = v && (m_q.size() < DEPTH);
    pp  = r && (m_q.size() != 0);
    @(posedge clk);
    if (pp)  void'(m_q.pop_front());
    if (acc) m_q.push_back('{d: stored_word(d, o, u), o: o, u: u, x: x});
    m_so = (acc && o) || (m_so && !clr);
    m_su = (acc && u) || (m_su && !clr);
    m_sx = (acc && x) || (m_sx && !clr);
    if (clr)                m_exc = (acc && (o || u)) ? 1 : 0;
    else if (acc && (o || u)) m_exc = (m_exc < EXC_MAX) ? m_exc + 1 : EXC_MAX;
    #1 chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [31:0] d,
                      input logic o, input logic u, input logic x);
    step(tag, 1'b1, d, o, u, x, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_so = 0; m_su = 0; m_sx = 0; m_exc = 0;
  endtask

  initial begin
    logic [31:0] seq [4];
    seq[0] = 32'h3F800000; seq[1] = 32'h40000000;
    seq[2] = 32'h40400000; seq[3] = 32'h40800000;

    rst_n = 1'b0; in_valid = 0; in_data = 0; in_overflow = 0; in_underflow = 0;
    in_inexact = 0; out_ready = 0; clear_sticky = 0;
    model_reset();
    #22;
    chk_all("reset");
    @(negedge clk); rst_n = 1'b1;
    idle("post_reset");

    // Single entry, one-cycle latency.
    push("push_4p0", 32'h40800000, 0, 0, 0);
    pop("pop_4p0");
    idle("empty_again");

    // Fill to DEPTH, reject a fifth, drain in order (pointers wrap through 0).
    for (int i = 0; i < 4; i++) push($sformatf("fill%0d", i), seq[i], 0, 0, 0);
    push("push_when_full", 32'hDEADBEEF, 1, 1, 1);
    step("full_push_pop", 1'b1, 32'h12345678, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pop($sformatf("drain%0d", i));
    pop("pop_when_empty");

    // Steady stream: one primed entry, then push+pop each cycle.
    push("prime", 32'h41000000, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      step($sformatf("stream%0d", i), 1'b1, 32'h41100000 + 32'(i), 0, 0, 0, 1'b1, 1'b0);
    pop("stream_drain");

    // Overflow push: sticky + counter, stored word may be saturated.
    push("ovf_push", 32'hC0000000, 1, 0, 0);
    pop("ovf_pop");

    // Clear with a simultaneous underflow push: the new event survives.
    step("clr_with_unf", 1'b1, 32'h00000001, 0, 1, 0, 1'b0, 1'b1);
    pop("unf_pop");

    // Counter saturation at 2^CW-1.
    for (int i = 0; i < 5; i++)
      step($sformatf("sat%0d", i), 1'b1, 32'h7F000000 + 32'(i), 1, 0, 0, 1'b1, 1'b0);
    step("clear_only", 1'b0, 32'h0, 0, 0, 0, 1'b1, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++)
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));

    // Asynchronous reset with three entries in flight.
    while (m_q.size() != 0) pop("pre_rst_drain");
    for (int i = 0; i < 3; i++) push($sformatf("pre_rst%0d", i), seq[i], 1, 0, 1);
    @(negedge clk);
    in_valid = 0; out_ready = 0; clear_sticky = 0;
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_all("async_reset");
    @(negedge clk); rst_n = 1'b1;
    idle("after_async_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
